// File: rtl/count_down_60.sv
// Mod-60 BCD down counter with run/stop FSM, clamped preset load and a borrow output.
// Define COUNT_DOWN_60_ONESHOT_EN to stop at 00 and drop to IDLE instead of wrapping to WRAP_VAL.
module count_down_60 #(
  parameter logic [6:0] WRAP_VAL = 7'b101_1001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [6:0] din,
  output logic [6:0] count,
  output logic       bo,
  output logic       run
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state;
  logic [3:0] ones;
  logic [2:0] tens;
  logic       ones_bo;
  logic       drop;

  function automatic logic [3:0] clamp_ones(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] d);
    return (d > 3'd5) ? 3'd5 : d;
  endfunction

  // Borrow chain mirrors the up counter's carry split; bo has no latency so it can drive a next stage's en.
  assign ones_bo = (ones == 4'd0) & en & run;
  assign bo      = (tens == 3'd0) & ones_bo & ~load;
  assign count   = {tens, ones};

`ifdef COUNT_DOWN_60_ONESHOT_EN
  assign drop = stop | bo;
`else
  assign drop = stop;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      run   <= 1'b0;
      ones  <= 4'd0;
      tens  <= 3'd0;
    end else begin
      if (load) begin
        ones <= clamp_ones(din[3:0]);
        tens <= clamp_tens(din[6:4]);
      end else if (run && en) begin
        if (ones != 4'd0) begin
          ones <= ones - 4'd1;
        end else if (tens != 3'd0) begin
          ones <= 4'd9;
          tens <= tens - 3'd1;
        end else begin
`ifdef COUNT_DOWN_60_ONESHOT_EN
          ones <= 4'd0;
          tens <= 3'd0;
`else
          ones <= WRAP_VAL[3:0];
          tens <= WRAP_VAL[6:4];
`endif
        end
      end

      // stop always wins over start
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          if (drop) begin
            state <= IDLE;
            run   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_down_60.sv
// Randomized and directed bench for count_down_60: two cascaded instances checked against an integer-valued model.
module tb_count_down_60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, start = 1'b0, stop = 1'b0;
  logic       load = 1'b0, load1 = 1'b0;
  logic [6:0] din = 7'd0, din1 = 7'd0;
  logic [6:0] count0, count1;
  logic       bo0, bo1, run0, run1;

  int tests = 0;
  int errors = 0;

  int mv[2];
  bit mrun[2];

  always #5 clk = ~clk;

  count_down_60 u0 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .load(load), .din(din), .count(count0), .bo(bo0), .run(run0)
  );

  count_down_60 u1 (
    .clk(clk), .rst(rst), .en(bo0), .start(start), .stop(stop),
    .load(load1), .din(din1), .count(count1), .bo(bo1), .run(run1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] to_bcd(input int v);
    int t, o;
    t = v / 10;
    o = v % 10;
    return {t[2:0], o[3:0]};
  endfunction

  function automatic int preset_val(input logic [6:0] d);
    int t, o;
    t = int'(d[6:4]);
    o = int'(d[3:0]);
    if (t > 5) t = 5;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  task automatic model_next(input int i, input bit e, input bit l, input logic [6:0] d, input bit b);
    int nv;
    bit nr;
    nv = mv[i];
    nr = mrun[i];
    if (l) nv = preset_val(d);
    else if (mrun[i] && e) begin
`ifdef COUNT_DOWN_60_ONESHOT_EN
      nv = (mv[i] == 0) ? 0 : mv[i] - 1;
`else
      nv = (mv[i] == 0) ? 59 : mv[i] - 1;
`endif
    end
    if (mrun[i]) begin
      if (stop) nr = 0;
`ifdef COUNT_DOWN_60_ONESHOT_EN
      else if (b) nr = 0;
`endif
    end else if (start && !stop) nr = 1;
    mv[i] = nv;
    mrun[i] = nr;
  endtask

  task automatic check_state();
    check("count0", count0, to_bcd(mv[0]));
    check("count1", count1, to_bcd(mv[1]));
    check("run0", run0, mrun[0]);
    check("run1", run1, mrun[1]);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit eb0, eb1;
    #1;
    eb0 = mrun[0] && en && !load && (mv[0] == 0);
    eb1 = mrun[1] && eb0 && !load1 && (mv[1] == 0);
    check("bo0", bo0, eb0);
    check("bo1", bo1, eb1);
    model_next(0, en, load, din, eb0);
    model_next(1, eb0, load1, din1, eb1);
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
  endtask

  task automatic step(input bit e, input bit s, input bit p, input bit l, input logic [6:0] d,
                      input bit l1, input logic [6:0] d1);
    en = e; start = s; stop = p; load = l; din = d; load1 = l1; din1 = d1;
    tick();
  endtask

  task automatic do_reset();
    en = 0; start = 0; stop = 0; load = 0; load1 = 0;
    #2;
    rst = 1'b0;
    #1;
    mv[0] = 0; mv[1] = 0; mrun[0] = 0; mrun[1] = 0;
    check("rst_count0", count0, 7'h00);
    check("rst_run0", run0, 1'b0);
    check("rst_bo0", bo0, 1'b0);
    check_state();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    mv[0] = 0; mv[1] = 0; mrun[0] = 0; mrun[1] = 0;
    @(negedge clk);
    do_reset();

`ifdef COUNT_DOWN_60_ONESHOT_EN
    step(0, 1, 0, 1, 7'h01, 1, 7'h00);
    step(1, 0, 0, 0, 0, 0, 0);
    check("os_count00", count0, 7'h00);
    step(1, 0, 0, 0, 0, 0, 0);
    check("os_hold00", count0, 7'h00);
    check("os_idle", run0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("os_idle2", run0, 1'b0);
`else
    // Test 1: run, reset mid-count, then free-run wrap and tens borrow
    step(0, 0, 0, 1, 7'h30, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (11) step(1, 0, 0, 0, 0, 0, 0);
    check("wrap_to_49", count0, 7'h49);

    // Test 2: clamped loads and load priority over decrement
    step(0, 0, 0, 1, 7'b111_1111, 0, 0);
    check("clamp_59", count0, 7'h59);
    step(0, 0, 0, 1, 7'b010_1100, 0, 0);
    check("clamp_29", count0, 7'h29);
    step(1, 0, 0, 1, 7'h37, 0, 0);
    check("load_37", count0, 7'h37);

    // Test 3: FSM priority
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    check("idle_both", run0, 1'b0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    check("run_both", run0, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("idle_hold", count0, 7'h37);

    // Test 4: load with start, then en gating
    step(0, 1, 0, 1, 7'h02, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("gate_00", count0, 7'h00);
    step(1, 0, 0, 0, 0, 0, 0);
    check("gate_59", count0, 7'h59);

    // Test 5: cascade
    step(0, 0, 1, 1, 7'h00, 1, 7'h05);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("casc_s0", count0, 7'h59);
    check("casc_s1", count1, 7'h04);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, ($urandom % 8) == 0, ($urandom % 20) == 0,
           ($urandom % 12) == 0, 7'($urandom), ($urandom % 12) == 0, 7'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
